cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Miss-handling controller that sits between the CPU data port, the 2-way set-associative write-back cache array and the word-wide data memory. It looks up each CPU request in the cache and stalls the CPU until the request can complete. On a miss it writes the LRU victim line back if it is valid and dirty, refills the 4-word line from memory, then replays the request, which is then guaranteed to hit. Address split: tag addr[31:9], index addr[8:4], word addr[3:2], byte addr[1:0].

## Interface
- ADDR_BITS, 32, address width
- TAG_BITS, 23, tag width
- LINE_WORDS, 4, words per line; the word counter is 2 bits wide
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en_r  in  1  CPU read request
- en_w  in  1  CPU write request
- addr_rw  in  ADDR_BITS  CPU byte address
- u_b_h_w  in  3  CPU access width/signedness, passed to the cache
- data_w  in  32  CPU write data
- data_r  out  32  read data; equals cache_dout
- stall  out  1  CPU must hold its request while high
- cache_addr  out  ADDR_BITS  cache address
- cache_load  out  1  cache load strobe
- cache_edit  out  1  cache CPU-write strobe
- cache_store  out  1  cache refill-word strobe
- cache_invalid  out  1  constant 0
- cache_u_b_h_w  out  3  cache width select
- cache_din  out  32  cache write data
- cache_hit, cache_valid, cache_dirty  in  1  registered cache status (victim-way valid/dirty)
- cache_tag  in  TAG_BITS  registered victim tag
- cache_dout  in  32  registered cache data
- mem_cs_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_BITS  word-aligned memory address
- mem_data_o  out  32  memory write data
- mem_data_i  in  32  memory read data, valid when mem_ack_i=1
- mem_ack_i  in  1  completes the current memory request

## Operation
- Registers: state, 2-bit cnt, req_addr. CPU request is legal only while stall rule is honoured (addr/data held stable while stall=1).
- IDLE: on en_r|en_w, latch req_addr=addr_rw; drive cache_addr=addr_rw, cache_u_b_h_w=u_b_h_w, cache_din=data_w, cache_load=en_r&!en_w, cache_edit=en_w; go to LOOKUP. With both en_r and en_w high, the request is treated as a write.
- LOOKUP: all cache strobes are 0; cache_addr=req_addr.
  - cache_hit=1: request is complete; go to IDLE.
  - Miss with cache_valid&cache_dirty: cnt=0; go to WB_RD.
  - Other miss: cnt=0; go to FL_GAP.
- WB_RD: cache_addr={req tag,index,cnt,00}; cache_load=0, so the cache returns the victim word; mem_cs_o=0. Go to WB_WR.
- WB_WR: cache_addr unchanged; mem_cs_o=1, mem_we_o=1, mem_addr_o={cache_tag,index,cnt,00}, mem_data_o=cache_dout. On mem_ack_i: if cnt==3, set cnt=0 and go to FL_GAP; otherwise cnt+1 and go to WB_RD.
- FL_GAP: mem_cs_o=0 for one cycle; go to FL_RD.
- FL_RD: mem_cs_o=1, mem_we_o=0, mem_addr_o={req tag,index,cnt,00}. In the mem_ack_i cycle: cache_store=1, cache_addr=mem_addr_o, cache_din=mem_data_i, cache_u_b_h_w=3'b010. Then, if cnt==3, go to IDLE (replay); otherwise cnt+1 and go to FL_GAP.
- stall = (IDLE & (en_r|en_w)) | (LOOKUP & !cache_hit) | WB_RD | WB_WR | FL_GAP | FL_RD.
- Refill never touches the recent bits, so all 4 words land in the same victim way.
- mem_cs_o is low for at least one cycle after every ack.

## Timing
- Reset: state=IDLE, cnt=0, req_addr=0. While rst=1, every output is 0 (stall, mem_cs_o, mem_we_o, all cache strobes, addresses, data).
- Reset mid-miss aborts immediately: no further mem_cs_o and no cache_store on the next cycle. A partially refilled line stays valid-but-stale; that is accepted.
- L = FL_RD/WB_WR cycles up to and including the ack cycle (L ≥ 1).
  - Hit: 1 stall cycle; data_r is valid in the LOOKUP cycle where stall=0.
  - Clean miss: 4L+7 stall cycles.
  - Dirty miss: adds 4(L+1) stall cycles.
- mem_ack_i while mem_cs_o=0 is ignored.
- Requests in IDLE with en_r=en_w=0 leave the state in IDLE and drive no cache strobes.

## Test plan
- Read hit: preload line 0x0000_0100, read LW 0x104 -> stall high 1 cycle, data_r=preloaded word, no mem_cs_o.
- Clean read miss, L=2: LW 0x0000_1208 -> mem reads 0x1200,0x1204,0x1208,0x120C each with a 1-cycle cs gap, 4 cache_store pulses, stall 15 cycles, data_r=mem[0x1208].
- Dirty victim: fill both ways of index 3, SW dirty the LRU way, read a third tag in index 3 -> 4 mem writes of the old line to {old tag,3,k,00} with the written data, then 4 reads, then hit.
- Write miss: SB 0xAB to 0x2001 on an empty cache -> refill, then cache_edit on the replay; a later LBU 0x2001 returns 0x0000_00AB.
- Reset mid-FL_RD (cnt=2) -> next cycle stall=0, mem_cs_o=0, state IDLE; a new read completes normally.
- en_r=en_w=1 -> treated as a write (cache_edit=1, cache_load=0).

Source files
------------

// File: rtl/cache_ctrl_if.sv
// Word-wide data-memory bus between the miss controller (master) and memory (slave).
interface cache_ctrl_if #(
  parameter int ADDR_BITS = 32
) ();
  logic                 mem_cs_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [31:0]          mem_data_o;
  logic [31:0]          mem_data_i;
  logic                 mem_ack_i;

  modport master (
    output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/cache_ctrl.sv
// Miss-handling controller for a 2-way write-back cache: lookup, dirty-victim
// write-back, 4-word line refill, then replay of the stalled CPU request.
module cache_ctrl #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_edit,
  output logic                 cache_store,
  output logic                 cache_invalid,
  output logic [2:0]           cache_u_b_h_w,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [31:0]          cache_dout,
  cache_ctrl_if.master         mem
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam int IDX_W = ADDR_BITS - TAG_BITS - OFF_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB_RD, WB_WR, FL_GAP, FL_RD} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [ADDR_BITS-1:0] req_addr, req_addr_nx;

  logic                 stall_c, load_c, edit_c, store_c, cs_c, we_c;
  logic [ADDR_BITS-1:0] addr_c, maddr_c;
  logic [2:0]           ubhw_c;
  logic [31:0]          din_c, mdata_c;

  // Word cnt of the requested line, and the same word of the victim line.
  logic [ADDR_BITS-1:0] line_addr, victim_addr;
  assign line_addr   = {req_addr[ADDR_BITS-1:OFF_W], cnt, 2'b00};
  assign victim_addr = {cache_tag, req_addr[OFF_W+IDX_W-1:OFF_W], cnt, 2'b00};

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_addr <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      req_addr <= req_addr_nx;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch can infer a latch.
    state_nx    = state;
    cnt_nx      = cnt;
    req_addr_nx = req_addr;
    stall_c     = 1'b0;
    addr_c      = '0;
    load_c      = 1'b0;
    edit_c      = 1'b0;
    store_c     = 1'b0;
    ubhw_c      = '0;
    din_c       = '0;
    cs_c        = 1'b0;
    we_c        = 1'b0;
    maddr_c     = '0;
    mdata_c     = '0;

    unique case (state)
      IDLE: begin
        if (en_r | en_w) begin
          req_addr_nx = addr_rw;
          addr_c      = addr_rw;
          ubhw_c      = u_b_h_w;
          din_c       = data_w;
          load_c      = en_r & ~en_w;
          edit_c      = en_w;
          stall_c     = 1'b1;
          state_nx    = LOOKUP;
        end
      end
      LOOKUP: begin
        addr_c = req_addr;
        if (cache_hit) begin
          state_nx = IDLE;
        end else begin
          stall_c  = 1'b1;
          cnt_nx   = '0;
          state_nx = (cache_valid & cache_dirty) ? WB_RD : FL_GAP;
        end
      end
      WB_RD: begin
        // Address the victim word with load low; its data arrives next cycle.
        stall_c  = 1'b1;
        addr_c   = line_addr;
        state_nx = WB_WR;
      end
      WB_WR: begin
        stall_c = 1'b1;
        addr_c  = line_addr;
        cs_c    = 1'b1;
        we_c    = 1'b1;
        maddr_c = victim_addr;
        mdata_c = cache_dout;
        if (mem.mem_ack_i) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = FL_GAP;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = WB_RD;
          end
        end
      end
      FL_GAP: begin
        stall_c  = 1'b1;
        state_nx = FL_RD;
      end
      FL_RD: begin
        stall_c = 1'b1;
        addr_c  = line_addr;
        cs_c    = 1'b1;
        maddr_c = line_addr;
        if (mem.mem_ack_i) begin
          store_c = 1'b1;
          din_c   = mem.mem_data_i;
          ubhw_c  = 3'b010;
          if (cnt == CNT_LAST) begin
            state_nx = IDLE;
          end else begin
            cnt_nx   = cnt + 1'b1;
            state_nx = FL_GAP;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset forces every output low at once, so a miss aborts in the reset cycle itself.
  assign stall          = stall_c & ~rst;
  assign cache_addr     = rst ? '0 : addr_c;
  assign cache_load     = load_c & ~rst;
  assign cache_edit     = edit_c & ~rst;
  assign cache_store    = store_c & ~rst;
  assign cache_invalid  = 1'b0;
  assign cache_u_b_h_w  = rst ? '0 : ubhw_c;
  assign cache_din      = rst ? '0 : din_c;
  assign data_r         = rst ? '0 : cache_dout;
  assign mem.mem_cs_o   = cs_c & ~rst;
  assign mem.mem_we_o   = we_c & ~rst;
  assign mem.mem_addr_o = rst ? '0 : maddr_c;
  assign mem.mem_data_o = rst ? '0 : mdata_c;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: behavioural 2-way cache array plus a
// fixed-latency word memory, with hand-computed expectations per request.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr_rw;
  logic [2:0]  u_b_h_w;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  logic [31:0] cache_addr;
  logic        cache_load, cache_edit, cache_store, cache_invalid;
  logic [2:0]  cache_u_b_h_w;
  logic [31:0] cache_din;
  logic        cache_hit = 1'b0, cache_valid = 1'b0, cache_dirty = 1'b0;
  logic [22:0] cache_tag = '0;
  logic [31:0] cache_dout = '0;

  cache_ctrl_if #(.ADDR_BITS(32)) mem_if ();

  cache_ctrl #(.ADDR_BITS(32), .TAG_BITS(23), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
    .cache_addr(cache_addr), .cache_load(cache_load), .cache_edit(cache_edit),
    .cache_store(cache_store), .cache_invalid(cache_invalid),
    .cache_u_b_h_w(cache_u_b_h_w), .cache_din(cache_din),
    .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_tag(cache_tag), .cache_dout(cache_dout), .mem(mem_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural cache array ----------------
  logic [22:0] c_tag [2][32];
  logic        c_val [2][32];
  logic        c_dty [2][32];
  logic [31:0] c_dat [2][32][4];
  logic        c_lru [32];   // way to evict next

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] bo, input logic [2:0] f);
    logic [31:0] s;
    s = w >> (8 * bo);
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_fmt(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] bo, input logic [2:0] f);
    logic [31:0] m;
    case (f[1:0])
      2'b00:   m = 32'h0000_00FF << (8 * bo);
      2'b01:   m = 32'h0000_FFFF << (8 * bo);
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | ((d << (8 * bo)) & m);
  endfunction

  always @(posedge clk) begin : cache_model
    logic [4:0]  idx;
    logic [22:0] tg;
    logic [1:0]  wd, bo;
    logic        h, hw, vw;
    idx = cache_addr[8:4];
    tg  = cache_addr[31:9];
    wd  = cache_addr[3:2];
    bo  = cache_addr[1:0];
    h = 1'b0; hw = 1'b0;
    for (int w = 0; w < 2; w++)
      if (c_val[w][idx] && c_tag[w][idx] == tg) begin h = 1'b1; hw = w[0]; end
    vw = c_lru[idx];
    cache_valid <= c_val[vw][idx];
    cache_dirty <= c_dty[vw][idx];
    cache_tag   <= c_tag[vw][idx];
    cache_hit   <= (cache_load | cache_edit) & h;
    if (cache_store) begin
      c_dat[vw][idx][wd] = cache_din;
      c_tag[vw][idx]     = tg;
      c_val[vw][idx]     = 1'b1;
      c_dty[vw][idx]     = 1'b0;
      cache_dout <= cache_din;
    end else if (h && (cache_load || cache_edit)) begin
      if (cache_edit) begin
        c_dat[hw][idx][wd] = store_fmt(c_dat[hw][idx][wd], cache_din, bo, cache_u_b_h_w);
        c_dty[hw][idx]     = 1'b1;
      end
      c_lru[idx] = ~hw;
      cache_dout <= load_fmt(c_dat[hw][idx][wd], bo, cache_u_b_h_w);
    end else begin
      cache_dout <= c_dat[vw][idx][wd];
    end
  end

  // ---------------- word memory with latency lat ----------------
  int          lat = 2;
  int          cs_run = 0;
  logic [31:0] mem_map [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return a ^ 32'hDEAD_0000;
  endfunction

  initial begin
    mem_if.mem_ack_i  = 1'b0;
    mem_if.mem_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_if.mem_cs_o) begin
        cs_run++;
        mem_if.mem_ack_i  = (cs_run >= lat);
        mem_if.mem_data_i = mem_rd(mem_if.mem_addr_o);
        if (mem_if.mem_ack_i) cs_run = 0;
      end else begin
        cs_run = 0;
        mem_if.mem_ack_i  = 1'b0;
        mem_if.mem_data_i = '0;
      end
    end
  end

  // ---------------- negedge monitor ----------------
  logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
  int          store_cnt = 0, edit_cnt = 0, gap_err = 0;
  logic        prev_ack = 1'b0;

  always @(negedge clk) begin
    if (mem_if.mem_cs_o && prev_ack) gap_err++;
    prev_ack = mem_if.mem_cs_o & mem_if.mem_ack_i;
    if (mem_if.mem_cs_o && mem_if.mem_ack_i) begin
      if (mem_if.mem_we_o) begin
        mem_map[mem_if.mem_addr_o] = mem_if.mem_data_o;
        wr_addr_log.push_back(mem_if.mem_addr_o);
        wr_data_log.push_back(mem_if.mem_data_o);
      end else begin
        rd_log.push_back(mem_if.mem_addr_o);
      end
    end
    if (cache_store) store_cnt++;
    if (cache_edit)  edit_cnt++;
  end

  // ---------------- CPU request driver ----------------
  logic first_load, first_edit;

  task automatic cpu_req(input logic r, input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] d, output logic [31:0] rdata, output int stalls);
    bit done;
    done = 0;
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    store_cnt = 0; edit_cnt = 0;
    en_r = r; en_w = w; addr_rw = a; u_b_h_w = f; data_w = d;
    stalls = 0; rdata = '0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin first_load = cache_load; first_edit = cache_edit; end
      if (stall) stalls++;
      else begin rdata = data_r; done = 1; end
    end
    if (!done) check("req_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  logic [31:0] rd;
  int          st;
  bit          seen;

  initial begin
    for (int x = 0; x < 32; x++) begin
      c_lru[x] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        c_val[w][x] = 1'b0; c_dty[w][x] = 1'b0; c_tag[w][x] = '0;
        for (int k = 0; k < 4; k++) c_dat[w][x][k] = '0;
      end
    end
    // Line 0x100 preloaded in way 0 of index 16.
    c_val[0][16] = 1'b1; c_tag[0][16] = '0;
    for (int k = 0; k < 4; k++) c_dat[0][16][k] = 32'h1111_0000 + k;

    // Reset with a request pending: every output must stay low.
    rst = 1'b1; en_r = 1'b1; en_w = 1'b0; addr_rw = 32'h104; u_b_h_w = 3'b010; data_w = 32'hFFFF_FFFF;
    @(negedge clk); @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_load", 32'(cache_load), 0);
    check("rst_addr", cache_addr, 0);
    check("rst_din", cache_din, 0);
    check("rst_cs", 32'(mem_if.mem_cs_o), 0);
    @(posedge clk); #1;
    rst = 1'b0; en_r = 1'b0;
    @(negedge clk);
    check("idle_stall", 32'(stall), 0);
    check("idle_strobes", {30'b0, cache_load, cache_edit}, 0);
    @(posedge clk); #1;

    // Read hit.
    cpu_req(1, 0, 32'h104, 3'b010, 0, rd, st);
    check("hit_data", rd, 32'h1111_0001);
    check("hit_stalls", st, 1);
    check("hit_memrd", rd_log.size(), 0);

    // Clean read miss, L=2.
    cpu_req(1, 0, 32'h1208, 3'b010, 0, rd, st);
    check("clean_data", rd, 32'hDEAD_1208);
    check("clean_stalls", st, 15);
    check("clean_nrd", rd_log.size(), 4);
    foreach (rd_log[i]) check("clean_rd_addr", rd_log[i], 32'h1200 + 4 * i);
    check("clean_stores", store_cnt, 4);
    check("clean_nwr", wr_addr_log.size(), 0);

    // Dirty victim in index 3, L=3.
    lat = 3;
    cpu_req(1, 0, 32'h2030, 3'b010, 0, rd, st);
    check("fill_a", rd, 32'hDEAD_2030);
    cpu_req(1, 0, 32'h2230, 3'b010, 0, rd, st);
    check("fill_b", rd, 32'hDEAD_2230);
    cpu_req(0, 1, 32'h2034, 3'b010, 32'hCAFE_0001, rd, st);
    check("sw_stalls", st, 1);
    cpu_req(1, 0, 32'h2234, 3'b010, 0, rd, st);
    check("hit_b", rd, 32'hDEAD_2234);
    cpu_req(1, 0, 32'h2430, 3'b010, 0, rd, st);
    check("dirty_data", rd, 32'hDEAD_2430);
    check("dirty_stalls", st, 35);
    check("dirty_nwr", wr_addr_log.size(), 4);
    foreach (wr_addr_log[i]) check("dirty_wr_addr", wr_addr_log[i], 32'h2030 + 4 * i);
    if (wr_data_log.size() == 4) begin
      check("dirty_wr_d0", wr_data_log[0], 32'hDEAD_2030);
      check("dirty_wr_d1", wr_data_log[1], 32'hCAFE_0001);
      check("dirty_wr_d3", wr_data_log[3], 32'hDEAD_203C);
    end
    check("dirty_nrd", rd_log.size(), 4);
    foreach (rd_log[i]) check("dirty_rd_addr", rd_log[i], 32'h2430 + 4 * i);

    // Write miss: SB 0xAB to 0x2001, then LBU.
    lat = 2;
    cpu_req(0, 1, 32'h2001, 3'b000, 32'h0000_00AB, rd, st);
    check("wmiss_stalls", st, 15);
    check("wmiss_stores", store_cnt, 4);
    check("wmiss_edits", edit_cnt, 2);
    cpu_req(1, 0, 32'h2001, 3'b100, 0, rd, st);
    check("lbu_data", rd, 32'h0000_00AB);
    check("lbu_stalls", st, 1);

    // Reset during the third refill read.
    rd_log.delete(); store_cnt = 0;
    en_r = 1'b1; addr_rw = 32'h3008; u_b_h_w = 3'b010; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_cs_o && mem_if.mem_addr_o == 32'h3008) seen = 1;
    end
    check("abort_reach", 32'(seen), 1);
    check("abort_pre_stores", store_cnt, 2);
    @(posedge clk); #1;
    rst = 1'b1; en_r = 1'b0;
    @(negedge clk);
    check("abort_rst_cs", 32'(mem_if.mem_cs_o), 0);
    check("abort_rst_store", 32'(cache_store), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 0);
    check("abort_cs", 32'(mem_if.mem_cs_o), 0);
    @(negedge clk);
    check("abort_stores", store_cnt, 2);
    @(posedge clk); #1;
    cpu_req(1, 0, 32'h4010, 3'b010, 0, rd, st);
    check("after_abort_data", rd, 32'hDEAD_4010);
    check("after_abort_stalls", st, 15);

    // en_r and en_w together act as a write.
    cpu_req(1, 1, 32'h104, 3'b010, 32'h55AA_55AA, rd, st);
    check("rw_edit", 32'(first_edit), 1);
    check("rw_load", 32'(first_load), 0);
    cpu_req(1, 0, 32'h104, 3'b010, 0, rd, st);
    check("rw_readback", rd, 32'h55AA_55AA);

    check("cs_gap", gap_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
